// File: rtl/cnn_pool_pkg.sv
// Shared types and constants for the 2x2 max-pool window producer and its pooler.
package cnn_pool_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int WIN_W_DEF  = 4 * DATA_W_DEF;

  // Lane positions inside the packed window word.
  localparam int TL = 0;
  localparam int TR = 1;
  localparam int BL = 2;
  localparam int BR = 3;

  typedef enum logic {
    S_TOP    = 1'b0,
    S_BOTTOM = 1'b1
  } state_t;

endpackage

// File: rtl/pool_line_buf.sv
// One-line pixel store: single write port, single combinational read port, no reset.
module pool_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 26,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream to stride-2 2x2 window generator with frame tracking.
// Optional window counter output enabled by defining POOL_WINDOW_CNT_EN.
module pool_window_gen
  import cnn_pool_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int IMG_WIDTH  = 26,
  parameter int IMG_HEIGHT = 26
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_data_valid,
  output logic [4*DATA_W-1:0] o_window,
  output logic                o_window_valid,
  output logic                o_frame_done
`ifdef POOL_WINDOW_CNT_EN
  ,
  output logic [15:0]         o_window_cnt
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_MAX      = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX      = RW'(IMG_HEIGHT - 1);
  // Position of the bottom-right pixel of the final window (odd tails dropped).
  localparam logic [CW-1:0] COL_LAST_WIN = CW'((IMG_WIDTH / 2) * 2 - 1);
  localparam logic [RW-1:0] ROW_LAST_WIN = RW'((IMG_HEIGHT / 2) * 2 - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [DATA_W-1:0]   prev_px_q, prev_px_d;
  logic [DATA_W-1:0]   prev_top_q, prev_top_d;
  logic [4*DATA_W-1:0] window_q, window_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                col_wrap;
  logic                lb_we;
  logic [DATA_W-1:0]   lb_rdata;

  assign col_wrap = i_data_valid && (col_q == COL_MAX);
  assign lb_we    = i_data_valid && (state_q == S_TOP) && !i_reset;

  pool_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_WIDTH)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_we    (lb_we),
    .i_waddr (col_q),
    .i_wdata (i_data),
    .i_raddr (col_q),
    .o_rdata (lb_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_TOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (col_wrap) begin
      if (row_q == ROW_MAX) begin
        state_d = S_TOP;
      end else begin
        case (state_q)
          S_TOP:    state_d = S_BOTTOM;
          S_BOTTOM: state_d = S_TOP;
          default:  state_d = S_TOP;
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    prev_px_d  = prev_px_q;
    prev_top_d = prev_top_q;
    window_d   = window_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    if (i_data_valid) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (state_q == S_BOTTOM) begin
        // Even column captures the left half; the top-left comes from the line buffer now.
        if (!col_q[0]) begin
          prev_px_d  = i_data;
          prev_top_d = lb_rdata;
        end else begin
          window_d[TL*DATA_W +: DATA_W] = prev_top_q;
          window_d[TR*DATA_W +: DATA_W] = lb_rdata;
          window_d[BL*DATA_W +: DATA_W] = prev_px_q;
          window_d[BR*DATA_W +: DATA_W] = i_data;
          valid_d = 1'b1;
          done_d  = (row_q == ROW_LAST_WIN) && (col_q == COL_LAST_WIN);
        end
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      col_q      <= '0;
      row_q      <= '0;
      prev_px_q  <= '0;
      prev_top_q <= '0;
      window_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      prev_px_q  <= prev_px_d;
      prev_top_q <= prev_top_d;
      window_q   <= window_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

  assign o_window       = window_q;
  assign o_window_valid = valid_q;
  assign o_frame_done   = done_q;

`ifdef POOL_WINDOW_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        restart_q, restart_d;

  // Count restarts at 1 on the first window following a frame-done.
  always_comb begin
    cnt_d     = cnt_q;
    restart_d = restart_q;
    if (valid_d) begin
      cnt_d     = restart_q ? 16'd1 : cnt_q + 16'd1;
      restart_d = done_d;
    end else begin
      cnt_d     = cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q     <= 16'd0;
      restart_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
    end
  end

  assign o_window_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: default 26x26 instance plus a 5x3 instance.
module tb_pool_window_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic [63:0] a_win, b_win;
  logic        a_wv, b_wv, a_done, b_done;
`ifdef POOL_WINDOW_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int          win_total, done_total, frame_wins, last_done_at, done_gap;
  logic [63:0] first_win, last_win;

  always #5 clk = ~clk;

  pool_window_gen #(.DATA_W(16), .IMG_WIDTH(26), .IMG_HEIGHT(26)) dut_a (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_data         (a_data),
    .i_data_valid   (a_valid),
    .o_window       (a_win),
    .o_window_valid (a_wv),
    .o_frame_done   (a_done)
`ifdef POOL_WINDOW_CNT_EN
    ,
    .o_window_cnt   (a_cnt)
`endif
  );

  pool_window_gen #(.DATA_W(16), .IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_data         (b_data),
    .i_data_valid   (b_valid),
    .o_window       (b_win),
    .o_window_valid (b_wv),
    .o_frame_done   (b_done)
`ifdef POOL_WINDOW_CNT_EN
    ,
    .o_window_cnt   (b_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, outputs read 1 unit after the next edge.
  task automatic cyc(input bit sel_b, input bit v, input logic [15:0] d);
    a_valid = v && !sel_b;
    b_valid = v && sel_b;
    a_data  = d;
    b_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    win_total    = 0;
    done_total   = 0;
    last_done_at = 0;
    done_gap     = 0;
    first_win    = '0;
    last_win     = '0;
  endtask

  task automatic run_frame(input bit sel_b, input bit gap);
    int          w, h, exp_cnt;
    logic [15:0] px;
    logic [63:0] ew, ow;
    bit          ev, ed;
    logic        ov, od;
    logic [15:0] oc;
    w = sel_b ? 5 : 26;
    h = sel_b ? 3 : 26;
    frame_wins = 0;
    exp_cnt    = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = 16'(r * w + c);
        cyc(sel_b, 1'b1, px);
        ov = sel_b ? b_wv   : a_wv;
        od = sel_b ? b_done : a_done;
        ow = sel_b ? b_win  : a_win;
        oc = 16'd0;
`ifdef POOL_WINDOW_CNT_EN
        oc = sel_b ? b_cnt : a_cnt;
`endif
        ev = (r % 2 == 1) && (c % 2 == 1);
        ed = ev && (r == (h / 2) * 2 - 1) && (c == (w / 2) * 2 - 1);
        ew = {px, px - 16'd1, px - 16'(w), px - 16'(w + 1)};
        check("valid", {63'd0, ov}, {63'd0, ev});
        check("done", {63'd0, od}, {63'd0, ed});
        if (ev) begin
          exp_cnt++;
          check("window", ow, ew);
`ifdef POOL_WINDOW_CNT_EN
          check("win_cnt", {48'd0, oc}, 64'(exp_cnt));
`endif
        end
        if (ov === 1'b1) begin
          win_total++;
          frame_wins++;
          if (frame_wins == 1) first_win = ow;
          last_win = ow;
        end
        if (od === 1'b1) begin
          done_total++;
          done_gap     = win_total - last_done_at;
          last_done_at = win_total;
        end
        if (gap) begin
          cyc(sel_b, 1'b0, 16'hdead);
          ov = sel_b ? b_wv : a_wv;
          check("idle_valid", {63'd0, ov}, 64'd0);
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = 16'd0;
    b_data  = 16'd0;
    clear_stats();
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b1, 16'd99);
    check("rst_window_a", a_win, 64'd0);
    check("rst_valid_a", {63'd0, a_wv}, 64'd0);
    check("rst_done_a", {63'd0, a_done}, 64'd0);
    check("rst_window_b", b_win, 64'd0);
`ifdef POOL_WINDOW_CNT_EN
    check("rst_cnt_a", {48'd0, a_cnt}, 64'd0);
`endif
    rst = 1'b0;

    // Single frame, continuous valid.
    run_frame(1'b0, 1'b0);
    check("f1_windows", 64'(win_total), 64'd169);
    check("f1_dones", 64'(done_total), 64'd1);
    check("f1_first", first_win, 64'h001b_001a_0001_0000);
    check("f1_last", last_win, 64'h02a3_02a2_0289_0288);
`ifdef POOL_WINDOW_CNT_EN
    check("f1_cnt_end", {48'd0, a_cnt}, 64'd169);
`endif

    // Same frame with an idle cycle after every pixel.
    clear_stats();
    run_frame(1'b0, 1'b1);
    check("gap_windows", 64'(win_total), 64'd169);
    check("gap_first", first_win, 64'h001b_001a_0001_0000);
    check("gap_last", last_win, 64'h02a3_02a2_0289_0288);

    // Two frames back-to-back.
    clear_stats();
    run_frame(1'b0, 1'b0);
    run_frame(1'b0, 1'b0);
    check("b2b_windows", 64'(win_total), 64'd338);
    check("b2b_dones", 64'(done_total), 64'd2);
    check("b2b_done_gap", 64'(done_gap), 64'd169);
    check("b2b_first2", first_win, 64'h001b_001a_0001_0000);

    // Reset after 40 pixels, with a valid pixel in the reset cycle.
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 16'(i));
    rst = 1'b1;
    cyc(1'b0, 1'b1, 16'h7777);
    check("mid_rst_window", a_win, 64'd0);
    check("mid_rst_valid", {63'd0, a_wv}, 64'd0);
    check("mid_rst_done", {63'd0, a_done}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'd0);
      check("post_rst_valid", {63'd0, a_wv}, 64'd0);
    end
    clear_stats();
    run_frame(1'b0, 1'b0);
    check("rst_f_windows", 64'(win_total), 64'd169);
    check("rst_f_dones", 64'(done_total), 64'd1);
    check("rst_f_first", first_win, 64'h001b_001a_0001_0000);
    check("rst_f_last", last_win, 64'h02a3_02a2_0289_0288);

    // 5x3 instance: odd width and odd height tails are dropped.
    clear_stats();
    run_frame(1'b1, 1'b0);
    check("small_windows", 64'(win_total), 64'd2);
    check("small_dones", 64'(done_total), 64'd1);
    check("small_first", first_win, 64'h0006_0005_0001_0000);
    check("small_last", last_win, 64'h0008_0007_0003_0002);
    cyc(1'b1, 1'b0, 16'd0);
    check("small_idle", {63'd0, b_wv}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
Producer side of the 2x2 max-pool interface. Accepts a raster-order pixel stream from the convolution stage, one pixel per valid cycle. Buffers one line and emits non-overlapping 2x2 windows (stride 2) as a packed 64-bit word with a valid strobe, which connects directly to the pooler's data and valid inputs. Generates its own frame-position tracking, so the downstream pooler needs no window-position logic.

Parameters:
DATA_W, 16, pixel width in bits; the window word is 4*DATA_W.
IMG_WIDTH, 26, pixels per input row; must be >= 2.
IMG_HEIGHT, 26, rows per input frame; must be >= 2.

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_data  in  DATA_W  input pixel, two's-complement-agnostic (unsigned container).
i_data_valid  in  1  i_data is valid this cycle; no backpressure.
o_window  out  4*DATA_W  [DATA_W-1:0]=top-left, [2DW-1:DW]=top-right, [3DW-1:2DW]=bottom-left, [4DW-1:3DW]=bottom-right.
o_window_valid  out  1  one-cycle strobe; o_window is valid this cycle.
o_frame_done  out  1  one-cycle strobe, coincident with the last window of a frame.

Behaviour:
- Reset (i_reset=1 at an edge): col=0, row=0, state=S_TOP, o_window=0, o_window_valid=0, o_frame_done=0. Line-buffer contents are don't-care and are never read before being rewritten.
- Counters advance only on cycles with i_data_valid=1. Idle cycles freeze all state, and o_window_valid=0 on those cycles.
- col counts 0..IMG_WIDTH-1 and wraps to 0, which increments row. row counts 0..IMG_HEIGHT-1 and wraps to 0 at the end of the frame.
- State machine keyed on row parity:
  - S_TOP (even row): each pixel is written to linebuf[col]. No output. On col wrap -> S_BOTTOM.
  - S_BOTTOM (odd row):
    - Even col: the pixel is latched in prev_px.
    - Odd col: the window {i_data, prev_px, linebuf[col], linebuf[col-1]} is registered to o_window and o_window_valid=1 on the next cycle.
    - Latency: exactly 1 cycle after the bottom-right pixel is accepted.
    - On col wrap -> S_TOP.
- Odd IMG_WIDTH: the last column is dropped; no window is emitted for it.
- Odd IMG_HEIGHT: the last row is written into the line buffer but never paired. Frame wrap still occurs after row IMG_HEIGHT-1.
- Windows per row = IMG_WIDTH/2 (13 at default). Windows per frame = (IMG_WIDTH/2)*(IMG_HEIGHT/2) (169 at default).
- o_frame_done=1 in the same cycle as the last window's valid. The next accepted pixel is (0,0) of the next frame. Back-to-back frames need no gap.
- Reset mid-frame discards the partial frame: no window or done pulse for it. The next valid pixel is (0,0).
- If reset and valid are both high in the same cycle, reset wins and the pixel is dropped.
- Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT), with explicit compare-to-max wrap (not power-of-2 overflow).

Optional Feature:
POOL_WINDOW_CNT_EN:
- Defined: adds output o_window_cnt (16 bits).
  - Reset value 0; increments on each o_window_valid.
  - Reloads to 1 on the first window after an o_frame_done, so that after the last window it reads 169 at default.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package cnn_pool_pkg:
  - DATA_W default and window-word width constant.
  - Lane index constants TL=0, TR=1, BL=2, BR=3.
  - State typedef (S_TOP, S_BOTTOM).
- One sub-module: pool_line_buf, a single-port-write / single-read IMG_WIDTH x DATA_W register array with combinational read. The generator holds the counters, FSM and output registers.

Test Plan:
- Stimulus: full 26x26 frame, continuous valid, pixel(r,c)=r*26+c. Response: first window {27,26,1,0} one cycle after pixel 27 is accepted; 169 valid strobes total; last window {675,674,649,648} with o_frame_done=1 on the same cycle.
- Stimulus: same frame with valid deasserted every other cycle. Response: identical window sequence; no valid on idle cycles; each window 1 cycle after its bottom-right pixel.
- Stimulus: two frames back-to-back with no gap. Response: second frame's first window is {27,26,1,0} again; exactly two o_frame_done pulses, 169 windows apart.
- Stimulus: reset asserted after 40 pixels, then a full frame. Response: no output after reset; the subsequent frame matches the first test exactly; o_window=0 during reset.
- Stimulus: IMG_WIDTH=5, IMG_HEIGHT=3 override, pixel = r*5+c. Response: exactly 2 windows, {6,5,1,0} and {8,7,3,2}; o_frame_done on the second; column 4 and row 2 produce nothing.
- Stimulus: POOL_WINDOW_CNT_EN defined, full default frame. Response: o_window_cnt reads 169 after the last window, then 1 after the next frame's first window.
